// File: rtl/mul_div_unit_pkg.sv
// Shared sizes and command codes for the iterative multiply/divide unit.
// Signed operations are enabled at build time by MDU_SIGNED_EN.
package mul_div_unit_pkg;

  localparam int DATA_SIZE = 32;

  localparam logic [2:0] MDU_OP_MULU = 3'd0;
  localparam logic [2:0] MDU_OP_DIVU = 3'd1;
  localparam logic [2:0] MDU_OP_MULS = 3'd2;
  localparam logic [2:0] MDU_OP_DIVS = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  typedef enum logic [1:0] {
    MODE_MUL = 2'd0,
    MODE_DIV = 2'd1,
    MODE_NOP = 2'd2
  } mdu_mode_e;

  function automatic logic [DATA_SIZE-1:0] neg_word(input logic [DATA_SIZE-1:0] v);
    return {DATA_SIZE{1'b0}} - v;
  endfunction

  function automatic logic [2*DATA_SIZE-1:0] neg_dword(input logic [2*DATA_SIZE-1:0] v);
    return {(2*DATA_SIZE){1'b0}} - v;
  endfunction

  // Magnitude of a word when it is to be treated as a negative signed value.
  function automatic logic [DATA_SIZE-1:0] mag_word(input logic [DATA_SIZE-1:0] v, input logic neg);
    return neg ? neg_word(v) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Radix-2 iterative multiply/divide unit sharing one 64-bit accumulator.
// Define MDU_SIGNED_EN to give ops 2/3 signed semantics; otherwise they alias ops 0/1.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_oe,
  input  logic [2:0]           op,
  input  logic [DATA_SIZE-1:0] a,
  input  logic [DATA_SIZE-1:0] b,
  input  logic                 q,
  output logic [DATA_SIZE-1:0] out,
  output logic [DATA_SIZE-1:0] out_h,
  output logic                 dn,
  output logic                 busy
);

  mdu_state_e             state_r, state_nxt_s;
  mdu_mode_e              mode_r, mode_s;
  logic [4:0]             cnt_r;
  logic [2*DATA_SIZE-1:0] acc_r, acc_step_s, res_s;
  logic [DATA_SIZE-1:0]   b_r;
  logic                   neg_q_r, neg_r_r;
  logic                   signed_s, sa_s, sb_s;
  logic [DATA_SIZE:0]     mul_sum_s, div_rem_s;
  logic [DATA_SIZE-1:0]   div_diff_s;
  logic                   div_ge_s;
  logic [DATA_SIZE-1:0]   out_r, out_h_r;
  logic                   dn_r, busy_r;

  // Operand decode at accept: operation class and operand signs.
  always_comb begin
    signed_s = 1'b0;
`ifdef MDU_SIGNED_EN
    if ((op == MDU_OP_MULS) || (op == MDU_OP_DIVS)) begin
      signed_s = 1'b1;
    end else begin
      signed_s = 1'b0;
    end
`endif
    sa_s = signed_s & a[DATA_SIZE-1];
    sb_s = signed_s & b[DATA_SIZE-1];
    case (op)
      MDU_OP_MULU, MDU_OP_MULS: mode_s = MODE_MUL;
      MDU_OP_DIVU, MDU_OP_DIVS: mode_s = MODE_DIV;
      default:                  mode_s = MODE_NOP;
    endcase
  end

  // One radix-2 step on the shared accumulator, plus the sign fix-up of the final step.
  always_comb begin
    mul_sum_s = {1'b0, acc_r[2*DATA_SIZE-1:DATA_SIZE]} + (acc_r[0] ? {1'b0, b_r} : {(DATA_SIZE+1){1'b0}});
    div_rem_s = acc_r[2*DATA_SIZE-1:DATA_SIZE-1];
    div_ge_s  = (div_rem_s >= {1'b0, b_r});
    // A remainder that needs bit 32 is always >= b, so the 32-bit difference is exact.
    if (div_ge_s) begin
      div_diff_s = div_rem_s[DATA_SIZE-1:0] - b_r;
    end else begin
      div_diff_s = div_rem_s[DATA_SIZE-1:0];
    end
    if (mode_r == MODE_MUL) begin
      acc_step_s = {mul_sum_s, acc_r[DATA_SIZE-1:1]};
    end else begin
      acc_step_s = {div_diff_s, acc_r[DATA_SIZE-2:0], div_ge_s};
    end
    case (mode_r)
      MODE_MUL: res_s = neg_q_r ? neg_dword(acc_step_s) : acc_step_s;
      MODE_DIV: res_s = {(neg_r_r ? neg_word(acc_step_s[2*DATA_SIZE-1:DATA_SIZE]) : acc_step_s[2*DATA_SIZE-1:DATA_SIZE]),
                         (neg_q_r ? neg_word(acc_step_s[DATA_SIZE-1:0]) : acc_step_s[DATA_SIZE-1:0])};
      default:  res_s = {(2*DATA_SIZE){1'b0}};
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (q) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if ((mode_r == MODE_NOP) || (cnt_r == 5'd0)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, datapath and output registers; nothing moves on edges without clk_oe.
  always_ff @(posedge clk) begin
    if (clk_oe) begin
      if (rst) begin
        state_r <= ST_IDLE;
        mode_r  <= MODE_NOP;
        cnt_r   <= 5'd0;
        acc_r   <= {(2*DATA_SIZE){1'b0}};
        b_r     <= {DATA_SIZE{1'b0}};
        neg_q_r <= 1'b0;
        neg_r_r <= 1'b0;
        out_r   <= {DATA_SIZE{1'b0}};
        out_h_r <= {DATA_SIZE{1'b0}};
        dn_r    <= 1'b0;
        busy_r  <= 1'b0;
      end else begin
        state_r <= state_nxt_s;
        dn_r    <= (state_nxt_s == ST_DONE);
        busy_r  <= (state_nxt_s != ST_IDLE);
        case (state_r)
          ST_IDLE: begin
            if (q) begin
              mode_r  <= mode_s;
              cnt_r   <= 5'd31;
              acc_r   <= {{DATA_SIZE{1'b0}}, mag_word(a, sa_s)};
              b_r     <= mag_word(b, sb_s);
              // Divide by zero keeps an all-ones quotient, so never negate it.
              neg_q_r <= (sa_s ^ sb_s) & (b != {DATA_SIZE{1'b0}});
              neg_r_r <= sa_s;
            end
          end
          ST_RUN: begin
            acc_r <= acc_step_s;
            cnt_r <= cnt_r - 5'd1;
            if (state_nxt_s == ST_DONE) begin
              out_r   <= res_s[DATA_SIZE-1:0];
              out_h_r <= res_s[2*DATA_SIZE-1:DATA_SIZE];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out   = out_r;
  assign out_h = out_h_r;
  assign dn    = dn_r;
  assign busy  = busy_r;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have ports (clock and reset first); one clock, reset synchronous and active-high:
 clk  in  1  system clock, all state on posedge
 rst  in  1  synchronous active-high reset
 clk_oe  in  1  clock qualifier; state advances only on edges with clk_oe=1 ("enabled edge")
 op  in  3  operation code, sampled at accept
 a  in  DATA_SIZE  operand A / dividend, sampled at accept
 b  in  DATA_SIZE  operand B / divisor, sampled at accept
 q  in  1  request from initiator
 out  out  DATA_SIZE  product low word / quotient
 out_h  out  DATA_SIZE  product high word / remainder
 dn  out  1  result valid, one enabled cycle
 busy  out  1  request accepted, not yet retired
REQ-002 SHALL use DATA_SIZE=32 from the shared sizes header.

Function
REQ-003 SHALL implement states IDLE, RUN, DONE; busy=1 in RUN and DONE, dn=1 only in DONE.
REQ-004 SHALL accept on enabled edge with state IDLE and q=1: latch op/a/b, counter=31, go RUN.
REQ-005 SHALL ignore q while busy=1 and on edges with clk_oe=0.
REQ-006 SHALL perform one radix-2 step per enabled edge in RUN: shift-add multiply, restoring divide.
REQ-007 SHALL enter DONE on the enabled edge where counter=0 completes its step: dn=1, out/out_h loaded, i.e. dn visible 32 enabled edges after accept.
REQ-008 SHALL return DONE->IDLE on next enabled edge: dn=0, busy=0; IDLE accepts a new q on the following enabled edge.
REQ-009 SHALL hold out/out_h stable from DONE entry until the next DONE entry (no partial results visible).
REQ-010 op 0 MULU: {out_h,out} = a*b unsigned, full 64 bits.
REQ-011 op 1 DIVU: out = a/b, out_h = a%b, unsigned.
REQ-012 Divide by zero SHALL give out=32'hFFFFFFFF, out_h=a, same latency.
REQ-013 op 4..7 SHALL give out=0, out_h=0 with dn after one RUN edge.
REQ-014 clk_oe=0 SHALL freeze all state and outputs (dn/busy hold).

Reset
REQ-015 rst=1 on an enabled edge SHALL force IDLE, counter=0, out=0, out_h=0, dn=0, busy=0, including mid-RUN or in DONE; the pending operation is dropped, no dn.
REQ-016 rst SHALL take priority over q on the same edge.

Configuration
REQ-017 Macro MDU_SIGNED_EN defined: op 2 MULS (64-bit two's-complement product), op 3 DIVS (quotient truncated toward zero, remainder sign of a; a/0 per REQ-012); sign fix-up folded into the final step, latency unchanged.
REQ-018 MDU_SIGNED_EN undefined: op 2 behaves as op 0, op 3 as op 1.

Structure
REQ-019 Op codes MDU_OP_MULU=0, MDU_OP_DIVU=1, MDU_OP_MULS=2, MDU_OP_DIVS=3 and state encodings SHALL live in the shared command-codes header; DATA_SIZE from sizes header.
REQ-020 SHALL be a single module, no sub-modules; the iteration datapath shares one 64-bit accumulator between multiply and divide.

Verification
REQ-021 op0, a=32'hFFFFFFFF, b=2 -> dn after 32 enabled edges, out_h=1, out=32'hFFFFFFFE.
REQ-022 op1, a=100, b=7 -> out=14, out_h=2; then op1 b=0, a=5 -> out=32'hFFFFFFFF, out_h=5.
REQ-023 With MDU_SIGNED_EN: op3 a=-7, b=2 -> out=-3, out_h=-1; op2 a=-3, b=4 -> {out_h,out}=64'hFFFFFFFF_FFFFFFF4. Without the macro: op2 equals op0 results.
REQ-024 clk_oe toggling every edge, q held high through a full transaction -> exactly one accept per IDLE, dn pulse one enabled cycle, count of enabled edges to dn = 32.
REQ-025 rst asserted at RUN step 10 -> next edge busy=0, dn=0, out=0; new request then completes with correct result.
